zamarine_activation_sequencer: RTL and testbench
================================================

// Module: zamarine_activation_sequencer
// PURPOSE
//  Upstream command stage for the Zamarine component status register. Accepts
//  activate/deactivate requests on a valid/ready port, buffers them in order,
//  drops redundant ones and enforces a settle gap after each activation
//  (inrush limiting). Drives the register's component_id/activate pair.
//  The register writes every cycle, so the outputs hold the last issued
//  command when idle; re-writing it is idempotent.
// PARAMETERS
//  MAX_COMPONENTS  8   number of components; ids >= this are illegal
//  ID_W            3   component id width
//  FIFO_DEPTH      4   request buffer entries (power of two, >= 2)
//  SETTLE_CYCLES   16  minimum cycles from an activation issue to the next issue; 0 = none
// PORTS
//  clk             in   1               clock
//  reset           in   1               asynchronous, active-high
//  req_valid       in   1               request present
//  req_ready       out  1               buffer can accept
//  req_id          in   ID_W            target component
//  req_activate    in   1               1 = activate, 0 = deactivate
//  comp_id         out  ID_W            to status register component_id
//  comp_activate   out  1               to status register activate
//  cmd_issued      out  1               1-cycle pulse: comp_* took a new command
//  shadow_status   out  MAX_COMPONENTS  predicted register status, 1 cycle ahead of it
//  busy            out  1               FIFO non-empty or in SETTLE
//  err_bad_id      out  1               1-cycle pulse: illegal id dropped
// BEHAVIOUR
//  - Reset (any time, incl. mid-settle): FIFO flushed; state IDLE; comp_id=0,
//    comp_activate=0, cmd_issued=0, shadow_status=0, err_bad_id=0, busy=0,
//    req_ready=1. This matches the register's cleared reset state.
//  - Accept on req_valid && req_ready. req_ready = !fifo_full, with no
//    same-cycle pop bypass.
//  - If accepted req_id >= MAX_COMPONENTS: not enqueued; err_bad_id is 1 in the
//    next cycle only.
//  - FSM states: IDLE, SETTLE. All registered outputs update on the clock edge.
//  - IDLE with FIFO head valid:
//      * Head redundant (shadow bit == head activate): pop. No issue; stay IDLE.
//      * Otherwise: pop and load comp_id/comp_activate from the head.
//        Set cmd_issued=1 for one cycle and update the shadow bit.
//        Activation with SETTLE_CYCLES>0: go to SETTLE with cnt=SETTLE_CYCLES-1.
//        Otherwise: stay IDLE.
//  - SETTLE: no pop or issue; cnt decrements each cycle; at cnt==0 go to IDLE.
//    An activation issued at edge E allows the next issue no earlier than edge
//    E+SETTLE_CYCLES. Deactivations also wait (strict FIFO order).
//  - Latency: request accepted at edge t into an empty FIFO in IDLE gives
//    comp_* valid after edge t+1. The register status updates at edge t+2.
//  - Commands issue in arrival order; at most one pop per cycle.
//  - comp_id/comp_activate hold between issues; never X after reset.
//  - FIFO pointers are ID-free, log2(FIFO_DEPTH)+1 bits wide, wrapping.
//    Full/empty come from the pointer MSB compare.
//  - busy = !fifo_empty || state==SETTLE.
// STRUCTURE
//  - zamarine_pkg:
//      * ID_W and MAX_COMPONENTS defaults
//      * typedef struct packed {logic [ID_W-1:0] id; logic activate;} zam_cmd_t
//      * typedef enum logic {IDLE, SETTLE} zam_seq_state_t
//  - One sub-module: zamarine_cmd_fifo. Synchronous FIFO of zam_cmd_t with
//    FIFO_DEPTH entries; ports push/pop/full/empty/head, async reset flush.
//  - FSM, settle counter and shadow register live in this module.
// TESTING
//  1 Reset: all outputs 0, req_ready=1, busy=0. Assert reset mid-SETTLE with a
//    full FIFO -> everything returns to reset values the same cycle.
//  2 Activate id 3 at edge t -> comp_id=3, comp_activate=1 and cmd_issued
//    after edge t+1; shadow_status=8'h08; busy stays high for 16 cycles.
//  3 Activate id 1, then id 2 the next cycle (SETTLE_CYCLES=16) -> the second
//    cmd_issued occurs exactly 16 cycles after the first.
//  4 Activate id 5 twice, then deactivate id 5 -> exactly two cmd_issued
//    pulses; shadow returns to 8'h00.
//  5 During SETTLE push 4 requests -> req_ready=0 on the 5th; it is accepted
//    once the first pop frees space; all 5 issue in order.
//  6 MAX_COMPONENTS=6, request id 7 -> err_bad_id pulses once; no cmd_issued;
//    shadow unchanged. Scoreboard shadow_status against a status-register model.

Source files
------------

// File: rtl/zamarine_pkg.sv
// Shared types and default sizes for the Zamarine activation sequencer.
package zamarine_pkg;

  localparam int ZAM_ID_W           = 3;
  localparam int ZAM_MAX_COMPONENTS = 8;

  typedef struct packed {
    logic [ZAM_ID_W-1:0] id;
    logic                activate;
  } zam_cmd_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } zam_seq_state_t;

endpackage

// File: rtl/zamarine_cmd_fifo.sv
// In-order command buffer; pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy counter.
module zamarine_cmd_fifo
  import zamarine_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  zam_cmd_t din,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output zam_cmd_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  zam_cmd_t    mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/zamarine_activation_sequencer.sv
// Orders activate/deactivate requests, drops redundant ones and spaces
// activations by a settle gap before driving the component status register.
//   state  | meaning
//   IDLE   | may pop the FIFO head and issue it to comp_*
//   SETTLE | inrush gap after an activation; nothing pops or issues
module zamarine_activation_sequencer
  import zamarine_pkg::*;
#(
  parameter int MAX_COMPONENTS = ZAM_MAX_COMPONENTS,
  parameter int ID_W           = ZAM_ID_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ID_W-1:0]           req_id,
  input  logic                      req_activate,
  output logic [ID_W-1:0]           comp_id,
  output logic                      comp_activate,
  output logic                      cmd_issued,
  output logic [MAX_COMPONENTS-1:0] shadow_status,
  output logic                      busy,
  output logic                      err_bad_id
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  zam_seq_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             fifo_full;
  logic             fifo_empty;
  zam_cmd_t         head;
  logic             accept;
  logic             bad_id;
  logic             pop;

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign bad_id    = accept && (int'(req_id) >= MAX_COMPONENTS);
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state == SETTLE);

  zamarine_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && !bad_id),
    .din   ('{id: req_id, activate: req_activate}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // The counter leaves SETTLE on the edge it would reach zero, so the next
  // issue lands exactly SETTLE_CYCLES edges after the activation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      comp_id       <= '0;
      comp_activate <= 1'b0;
      cmd_issued    <= 1'b0;
      shadow_status <= '0;
      err_bad_id    <= 1'b0;
    end else begin
      cmd_issued <= 1'b0;
      err_bad_id <= bad_id;
      case (state)
        IDLE: begin
          if (!fifo_empty && (shadow_status[head.id] != head.activate)) begin
            comp_id                <= head.id;
            comp_activate          <= head.activate;
            cmd_issued             <= 1'b1;
            shadow_status[head.id] <= head.activate;
            if (head.activate && (SETTLE_CYCLES > 1)) begin
              state <= SETTLE;
              cnt   <= CNT_LOAD;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zamarine_activation_sequencer.sv
// Directed plus random checks of the activation sequencer against a queue and
// timestamp model of its ordering, redundancy and settle-gap rules.
module tb_zamarine_activation_sequencer;

  localparam int MAXC   = 6;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_id = '0;
  logic            req_activate = 1'b0;
  logic [2:0]      comp_id;
  logic            comp_activate;
  logic            cmd_issued;
  logic [MAXC-1:0] shadow_status;
  logic            busy;
  logic            err_bad_id;

  zamarine_activation_sequencer #(
    .MAX_COMPONENTS(MAXC),
    .ID_W          (3),
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_id        (req_id),
    .req_activate  (req_activate),
    .comp_id       (comp_id),
    .comp_activate (comp_activate),
    .cmd_issued    (cmd_issued),
    .shadow_status (shadow_status),
    .busy          (busy),
    .err_bad_id    (err_bad_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic       act;
  } mcmd_t;

  mcmd_t           mq[$];
  logic [MAXC-1:0] m_sh;
  logic [2:0]      m_id;
  logic            m_act;
  logic            m_iss;
  logic            m_err;
  int              cyc;
  int              nxt;
  int              total = 0;
  int              bad = 0;
  int              iss_cyc[$];
  logic [2:0]      iss_id[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model: head handling first, then the new request
  // against the pre-edge occupancy (no same-cycle bypass).
  task automatic model_edge(input logic v, input logic [2:0] id, input logic a);
    int    sz;
    logic  rdy;
    mcmd_t h;
    sz    = mq.size();
    rdy   = (sz < DEPTH);
    m_iss = 1'b0;
    m_err = 1'b0;
    if (sz > 0 && cyc >= nxt) begin
      h = mq.pop_front();
      if (m_sh[h.id] !== h.act) begin
        m_id        = h.id;
        m_act       = h.act;
        m_iss       = 1'b1;
        m_sh[h.id]  = h.act;
        if (h.act) nxt = cyc + SETTLE;
      end
    end
    if (v && rdy) begin
      if (int'(id) >= MAXC) m_err = 1'b1;
      else begin
        h.id  = id;
        h.act = a;
        mq.push_back(h);
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("ready", req_ready, mq.size() < DEPTH);
    chk("busy", busy, (mq.size() > 0) || (nxt > cyc));
    chk("comp_id", comp_id, m_id);
    chk("comp_activate", comp_activate, m_act);
    chk("cmd_issued", cmd_issued, m_iss);
    chk("err_bad_id", err_bad_id, m_err);
    chk("shadow", shadow_status, m_sh);
  endtask

  task automatic step(input logic v, input logic [2:0] id, input logic a);
    req_valid    = v;
    req_id       = id;
    req_activate = a;
    @(posedge clk);
    model_edge(v, id, a);
    #1;
    if (cmd_issued) begin
      iss_cyc.push_back(cyc);
      iss_id.push_back(comp_id);
    end
    check_all();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    mq.delete();
    m_sh  = '0;
    m_id  = '0;
    m_act = 1'b0;
    m_iss = 1'b0;
    m_err = 1'b0;
    cyc   = 0;
    nxt   = 0;
    check_all();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_shadow", shadow_status, 0);
    chk("rst_comp", {comp_id, comp_activate, cmd_issued, err_bad_id}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int bound);
    int g;
    g = 0;
    while (busy && g < bound) begin
      step(1'b0, 3'd0, 1'b0);
      g++;
    end
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    int   g;
    int   bc;
    logic rp;

    do_reset();

    // Single activation: latency, shadow and busy length.
    step(1'b1, 3'd3, 1'b1);
    step(1'b0, 3'd0, 1'b0);
    chk("t2_id", comp_id, 3);
    chk("t2_act", comp_activate, 1);
    chk("t2_iss", cmd_issued, 1);
    chk("t2_shadow", shadow_status, 6'h08);
    bc = 2;
    g  = 0;
    while (busy && g < 40) begin
      step(1'b0, 3'd0, 1'b0);
      if (busy) bc++;
      g++;
    end
    chk("t2_busy_len", bc, SETTLE);

    // Back-to-back activations are spaced by the settle gap.
    iss_cyc.delete();
    step(1'b1, 3'd1, 1'b1);
    step(1'b1, 3'd2, 1'b1);
    g = 0;
    while (iss_cyc.size() < 2 && g < 60) begin
      step(1'b0, 3'd0, 1'b0);
      g++;
    end
    chk("t3_issues", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 2) chk("t3_gap", iss_cyc[1] - iss_cyc[0], SETTLE);
    drain(60);

    // Redundant activation dropped, deactivation issued.
    do_reset();
    iss_cyc.delete();
    step(1'b1, 3'd5, 1'b1);
    step(1'b1, 3'd5, 1'b1);
    step(1'b1, 3'd5, 1'b0);
    drain(100);
    chk("t4_count", iss_cyc.size(), 2);
    chk("t4_shadow", shadow_status, 0);

    // Fill the FIFO during settle; the fifth request waits for space.
    step(1'b1, 3'd0, 1'b1);
    step(1'b0, 3'd0, 1'b0);
    iss_id.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i), 1'b1);
    chk("t5_full_ready", req_ready, 0);
    chk("t5_busy", busy, 1);
    g = 0;
    do begin
      rp = req_ready;
      step(1'b1, 3'd5, 1'b1);
      g++;
    end while (!rp && g < 40);
    chk("t5_accepted", rp, 1);
    drain(200);
    chk("t5_count", iss_id.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < iss_id.size()) chk("t5_order", iss_id[i], i + 1);

    // Illegal ids are dropped with a single error pulse.
    iss_cyc.delete();
    step(1'b1, 3'd7, 1'b1);
    chk("t6_err", err_bad_id, 1);
    chk("t6_iss", cmd_issued, 0);
    step(1'b1, 3'd6, 1'b0);
    chk("t6_err2", err_bad_id, 1);
    step(1'b0, 3'd0, 1'b0);
    chk("t6_err_clr", err_bad_id, 0);
    chk("t6_no_issue", iss_cyc.size(), 0);
    chk("t6_shadow", shadow_status, 6'h3f);

    // Reset mid-settle with a full FIFO.
    do_reset();
    step(1'b1, 3'd2, 1'b1);
    step(1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b1);
    chk("t1_full", req_ready, 0);
    do_reset();

    // Random traffic against the model.
    repeat (800) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
